// File: rtl/vector_response_checker_pkg.sv
// Shared types and helpers for the vector response checker: FSM state encoding
// and the settle-counter width calculation.
package vector_response_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } vrc_state_e;

  // Counter only needs to reach SETTLE_CYC-1; keep at least one bit for SETTLE_CYC=1.
  function automatic int unsigned timerWidth(input int unsigned settleCyc);
    return (settleCyc <= 1) ? 1 : $clog2(settleCyc);
  endfunction

endpackage

// File: rtl/vector_response_checker_settle_timer.sv
// Settle-window counter: counts up from zero while not cleared and raises
// expire on the last cycle of a SETTLE_CYC-long window.
module settle_timer
  import vector_response_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expire
);

  localparam int unsigned   CW   = timerWidth(SETTLE_CYC);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] count_q, count_d;

  assign expire = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!expire) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vector_response_checker.sv
// Sweep-and-check companion for a small combinational DUT: walks every input
// vector, samples the response after a settle window and grades it against EXP_TABLE.
module vector_response_checker
  import vector_response_checker_pkg::*;
#(
  parameter int unsigned            N_IN       = 4,
  parameter logic [(1<<N_IN)-1:0]   EXP_TABLE  = '0,
  parameter int unsigned            SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [N_IN-1:0]        vec_out,
  input  logic                   dut_o,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_fail_vec,
  output logic                   first_fail_valid,
  output logic [(1<<N_IN)-1:0]   resp_word
);

  localparam int unsigned     NV       = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  vrc_state_e        state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     errCnt_q, errCnt_d;
  logic [N_IN-1:0]   ffVec_q, ffVec_d;
  logic              ffValid_q, ffValid_d;
  logic [NV-1:0]     resp_q, resp_d;

  logic              timerClear;
  logic              timerExpire;
  logic              mismatch;
  logic [N_IN:0]     errInc;

  // The timer runs only inside SETTLE, so every settle window starts from zero.
  assign timerClear = (state_q != ST_SETTLE);

  settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timerClear),
    .expire (timerExpire)
  );

  assign mismatch = dut_o ^ EXP_TABLE[vec_q];
  assign errInc   = errCnt_q + {{N_IN{1'b0}}, mismatch};

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    errCnt_d  = errCnt_q;
    ffVec_d   = ffVec_q;
    ffValid_d = ffValid_q;
    resp_d    = resp_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          vec_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          errCnt_d  = '0;
          ffVec_d   = '0;
          ffValid_d = 1'b0;
          resp_d    = '0;
        end
      end
      ST_SETTLE: begin
        if (timerExpire) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        resp_d[vec_q] = dut_o;
        errCnt_d      = errInc;
        if (mismatch && !ffValid_q) begin
          ffVec_d   = vec_q;
          ffValid_d = 1'b1;
        end
        // Pass is graded on the updated count so a last-vector error is not lost.
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (errInc == '0);
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + N_IN'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      errCnt_q  <= '0;
      ffVec_q   <= '0;
      ffValid_q <= 1'b0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      errCnt_q  <= errCnt_d;
      ffVec_q   <= ffVec_d;
      ffValid_q <= ffValid_d;
      resp_q    <= resp_d;
    end
  end

  assign vec_out          = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = errCnt_q;
  assign first_fail_vec   = ffVec_q;
  assign first_fail_valid = ffValid_q;
  assign resp_word        = resp_q;

endmodule
